// File: rtl/lcd_char_rx.sv
// HD44780-style 4-bit bus receiver maintaining a 32-character display image.
// Define LCD_RX_INIT_SEQ_EN to require the 8-bit init handshake before nibble mode.
module lcd_char_rx (
   input  logic         CCLK,
   input  logic         rst,
   input  logic         LCDE,
   input  logic         LCDRS,
   input  logic         LCDRW,
   input  logic [3:0]   LCDDAT,
   output logic [255:0] strdata,
   output logic         byte_valid,
   output logic [7:0]   byte_out,
   output logic         byte_is_data,
   output logic [4:0]   addr,
   output logic         ready,
   output logic         rd_err
);

`ifdef LCD_RX_INIT_SEQ_EN
   typedef enum logic [1:0] {INIT, NIB_HI, NIB_LO} state_t;
   localparam state_t RST_ST = INIT;
`else
   typedef enum logic [1:0] {NIB_HI, NIB_LO} state_t;
   localparam state_t RST_ST = NIB_HI;
`endif

   state_t     state;
   logic [1:0] e_s, rs_s, rw_s;
   logic       e_s3;
   logic [3:0] dat_s1, dat_s2;
   logic [3:0] hi;
   logic       hi_rs;
   logic       id;
   logic       fall;
   logic [7:0] nb;

   always_ff @(posedge CCLK or posedge rst) begin
      if (rst) begin
         e_s    <= '0;
         e_s3   <= 1'b0;
         rs_s   <= '0;
         rw_s   <= '0;
         dat_s1 <= '0;
         dat_s2 <= '0;
      end else begin
         e_s    <= {e_s[0], LCDE};
         e_s3   <= e_s[1];
         rs_s   <= {rs_s[0], LCDRS};
         rw_s   <= {rw_s[0], LCDRW};
         dat_s1 <= LCDDAT;
         dat_s2 <= dat_s1;
      end
   end

   assign fall = ~e_s[1] & e_s3;
   assign nb   = {hi, dat_s2};

   always_ff @(posedge CCLK or posedge rst) begin
      if (rst) begin
         state        <= RST_ST;
         strdata      <= {32{8'h20}};
         addr         <= '0;
         id           <= 1'b1;
         byte_out     <= '0;
         byte_is_data <= 1'b0;
         byte_valid   <= 1'b0;
         rd_err       <= 1'b0;
         ready        <= 1'b0;
         hi           <= '0;
         hi_rs        <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         rd_err     <= 1'b0;
`ifndef LCD_RX_INIT_SEQ_EN
         ready      <= 1'b1;
`endif
         if (fall && rw_s[1]) begin
            rd_err <= 1'b1;
         end else if (fall) begin
            unique case (state)
`ifdef LCD_RX_INIT_SEQ_EN
               INIT: begin
                  if (dat_s2 == 4'h2 && !rs_s[1]) begin
                     state <= NIB_HI;
                     ready <= 1'b1;
                  end
               end
`endif
               NIB_HI: begin
                  hi    <= dat_s2;
                  hi_rs <= rs_s[1];
                  state <= NIB_LO;
               end
               NIB_LO: begin
                  byte_out     <= nb;
                  byte_is_data <= hi_rs;
                  byte_valid   <= 1'b1;
                  state        <= NIB_HI;
                  if (hi_rs) begin
                     // ~addr == 31-addr: char 0 sits in the top byte
                     strdata[{~addr, 3'b000} +: 8] <= nb;
                     addr <= id ? addr + 5'd1 : addr - 5'd1;
                  end else begin
                     unique case (1'b1)
                        nb[7]: addr <= {nb[6], nb[3:0]};
                        nb == 8'h01: begin
                           strdata <= {32{8'h20}};
                           addr    <= '0;
                           id      <= 1'b1;
                        end
                        nb[7:1] == 7'h01: addr <= '0;
                        nb[7:2] == 6'h01: id <= nb[1];
                        default: ;
                     endcase
                  end
               end
               default: state <= RST_ST;
            endcase
         end
      end
   end

endmodule
